// File: rtl/aes_pkg.sv
// Shared constants and controller state encoding for the single-block AES-128 encoder.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_RND_W = 4;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 encoder: captures a pt/key pair, steps the key
// schedule and round datapath through rounds 0..NR, then holds the result for downstream.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int RND_W  = AES_RND_W,
  parameter int DATA_W = AES_BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pt,
  input  logic [DATA_W-1:0] in_key,
  input  logic              abort,
  output logic              ks_ena,
  output logic [RND_W-1:0]  rnd_no,
  output logic [DATA_W-1:0] key_q,
  output logic [DATA_W-1:0] pt_q,
  output logic              st_load,
  output logic              st_en,
  output logic              mix_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  aes_state_e        state_q, state_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [DATA_W-1:0] key_d, pt_d;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    key_d     = key_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    ks_ena    = 1'b0;
    st_load   = 1'b0;
    st_en     = 1'b0;
    mix_en    = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !abort;
        if (in_valid && !abort) begin
          key_d   = in_key;
          pt_d    = in_pt;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ks_ena  = 1'b1;
        st_load = 1'b1;
        rnd_d   = RND_W'(1);
        state_d = ROUND;
      end
      ROUND: begin
        ks_ena = 1'b1;
        st_en  = 1'b1;
        mix_en = (rnd_q != LAST_RND);
        if (rnd_q == LAST_RND) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          rnd_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rnd_d   = '0;
      end
    endcase

    // A cancel overrides any handshake but leaves the captured block untouched.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      rnd_d   = '0;
    end
  end

  assign rnd_no = rnd_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: the controller drives a behavioural key schedule and round
// datapath, and results are compared against a FIPS-197 reference encryption.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         abort;
  logic         ks_ena;
  logic [3:0]   rnd_no;
  logic [127:0] key_q;
  logic [127:0] pt_q;
  logic         st_load;
  logic         st_en;
  logic         mix_en;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [127:0] KV_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KV_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KV_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KV_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic         ks, ld, en, mix, ov, rdy, bsy;
    logic [3:0]   rnd;
    logic [127:0] ct, rk, kq, pq;
  } obs_t;

  obs_t rec [32];

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .abort     (abort),
    .ks_ena    (ks_ena),
    .rnd_no    (rnd_no),
    .key_q     (key_q),
    .pt_q      (pt_q),
    .st_load   (st_load),
    .st_en     (st_en),
    .mix_en    (mix_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (b^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] t;
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-8*(4*c)   -: 8];
        a1 = t[127-8*(4*c+1) -: 8];
        a2 = t[127-8*(4*c+2) -: 8];
        a3 = t[127-8*(4*c+3) -: 8];
        o[127-8*(4*c)   -: 8] = xtime(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ gmul(a2, 8'h03) ^ a3;
        o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ gmul(a3, 8'h03);
        o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_at_round(input logic [127:0] key, input int rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int i = 1; i <= rnd; i++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = xtime(rc);
    end
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) s = aes_round(s, key_at_round(key, r), r != 10);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- Key schedule and round datapath driven by the controller ----------------
  logic [127:0] rk;
  logic [127:0] dp_state;

  always_comb rk = ks_ena ? key_at_round(key_q, int'(rnd_no)) : 128'h0;

  always @(posedge clk) begin
    if (st_load)    dp_state <= pt_q ^ rk;
    else if (st_en) dp_state <= aes_round(dp_state, rk, mix_en);
  end

  // ---------------- Stimulus helpers (drive and record only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a block until accepted; returns at the first cycle after the accepting edge.
  task automatic offer(input logic [127:0] pt, input logic [127:0] key, output bit ok);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready never high within 50 cycles, required 1");
    end
  endtask

  // Records outputs for cycles 1..n after accept; out_ready rises after ready_after valid cycles.
  task automatic record(input int n, input int ready_after);
    int ov_seen;
    ov_seen = 0;
    for (int k = 1; k <= n; k++) begin
      out_ready = (ov_seen >= ready_after);
      #1;
      rec[k].ks  = ks_ena;
      rec[k].ld  = st_load;
      rec[k].en  = st_en;
      rec[k].mix = mix_en;
      rec[k].ov  = out_valid;
      rec[k].rdy = in_ready;
      rec[k].bsy = busy;
      rec[k].rnd = rnd_no;
      rec[k].ct  = dp_state;
      rec[k].rk  = rk;
      rec[k].kq  = key_q;
      rec[k].pq  = pt_q;
      if (out_valid) ov_seen++;
      tick();
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_handshake: {in_ready,busy,out_valid}=%b required 100",
               {in_ready, busy, out_valid});
    end
    checks++;
    if ({ks_ena, st_load, st_en, mix_en, rnd_no} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_enables: {ks,ld,en,mix,rnd}=%b required 0",
               {ks_ena, st_load, st_en, mix_en, rnd_no});
    end
    checks++;
    if ({key_q, pt_q} !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_capture: key_q=%h pt_q=%h required 0", key_q, pt_q);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vector();
    bit ok;
    offer(KV_PT, KV_KEY, ok);
    record(14, 0);
    checks++;
    if ({rec[11].ov, rec[12].ov, rec[13].ov} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL kv_latency: out_valid at E+11..13=%b required 010",
               {rec[11].ov, rec[12].ov, rec[13].ov});
    end
    checks++;
    if (rec[12].ct !== KV_CT) begin
      errors++;
      $display("[TB] FAIL kv_ciphertext: got %h required %h", rec[12].ct, KV_CT);
    end
    checks++;
    if ({rec[12].rdy, rec[13].rdy, rec[13].bsy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL kv_return_idle: {rdy12,rdy13,busy13}=%b required 010",
               {rec[12].rdy, rec[13].rdy, rec[13].bsy});
    end
  endtask

  task automatic test_round_sequence();
    bit ok;
    logic [8:0] exp_v;
    logic [8:0] got_v;
    offer(KV_PT, KV_KEY, ok);
    record(13, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)       exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
      else if (k <= 11) exp_v = {1'b1, 1'b0, 1'b1, (k - 1) != 10, 1'b0, 4'(k - 1)};
      else              exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10};
      got_v = {rec[k].ks, rec[k].ld, rec[k].en, rec[k].mix, rec[k].ov, rec[k].rnd};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL round_seq cycle %0d: {ks,ld,en,mix,ov,rnd}=%b required %b",
                 k, got_v, exp_v);
      end
    end
    checks++;
    if (rec[11].rk !== KV_RK10) begin
      errors++;
      $display("[TB] FAIL round10_key: got %h required %h", rec[11].rk, KV_RK10);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held;
    offer(KV_PT, KV_KEY, ok);
    record(20, 5);
    held = 1'b1;
    for (int k = 12; k <= 17; k++)
      if (!(rec[k].ov === 1'b1 && rec[k].ct === KV_CT && rec[k].rdy === 1'b0)) held = 1'b0;
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold: out_valid/ct/in_ready held over E+12..17=%b required 1", held);
    end
    checks++;
    if ({rec[18].ov, rec[18].rdy, rec[18].bsy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL bp_release: {ov,rdy,busy}=%b required 010",
               {rec[18].ov, rec[18].rdy, rec[18].bsy});
    end
  endtask

  task automatic test_random();
    bit ok;
    bit held;
    int d;
    int first;
    logic [127:0] pt, key, exp_ct;
    for (int n = 0; n < 4; n++) begin
      pt     = rand128();
      key    = rand128();
      d      = $urandom_range(0, 3);
      exp_ct = aes_encrypt(pt, key);
      offer(pt, key, ok);
      record(14 + d, d);
      first = 0;
      for (int k = 14 + d; k >= 1; k--) if (rec[k].ov) first = k;
      checks++;
      if (first != 12) begin
        errors++;
        $display("[TB] FAIL rand_latency blk %0d: first out_valid at E+%0d required E+12", n, first);
      end
      checks++;
      if (rec[12].ct !== exp_ct) begin
        errors++;
        $display("[TB] FAIL rand_ct blk %0d: got %h required %h", n, rec[12].ct, exp_ct);
      end
      held = 1'b1;
      for (int k = 12; k <= 12 + d; k++) if (!(rec[k].ov === 1'b1 && rec[k].ct === exp_ct)) held = 1'b0;
      for (int k = 1; k <= 14 + d; k++) if (!(rec[k].kq === key && rec[k].pq === pt)) held = 1'b0;
      if (!(rec[13 + d].ov === 1'b0 && rec[13 + d].rdy === 1'b1)) held = 1'b0;
      checks++;
      if (held !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_hold blk %0d (delay %0d): hold/handoff=%b required 1", n, d, held);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit seen_ov;
    logic [127:0] pt, key;
    in_pt    = rand128();
    in_key   = rand128();
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle_accept: busy=%b required 0", busy);
    end

    pt  = rand128();
    key = rand128();
    offer(pt, key, ok);
    repeat (4) tick();
    checks++;
    if (rnd_no !== 4'd4) begin
      errors++;
      $display("[TB] FAIL abort_round: rnd_no=%0d required 4", rnd_no);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    checks++;
    if ({busy, ks_ena, st_en, out_valid, rnd_no, in_ready} !== 9'b000000001) begin
      errors++;
      $display("[TB] FAIL abort_state: {busy,ks,en,ov,rnd,rdy}=%b required 000000001",
               {busy, ks_ena, st_en, out_valid, rnd_no, in_ready});
    end
    checks++;
    if (key_q !== key || pt_q !== pt) begin
      errors++;
      $display("[TB] FAIL abort_keep: key_q=%h pt_q=%h required %h %h", key_q, pt_q, key, pt);
    end
    seen_ov = 1'b0;
    repeat (15) begin
      if (out_valid) seen_ov = 1'b1;
      tick();
    end
    checks++;
    if (seen_ov !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_output: out_valid seen=%b required 0", seen_ov);
    end

    pt  = rand128();
    key = rand128();
    offer(pt, key, ok);
    record(13, 0);
    checks++;
    if (rec[12].ov !== 1'b1 || rec[12].ct !== aes_encrypt(pt, key)) begin
      errors++;
      $display("[TB] FAIL abort_recover: ov=%b ct=%h required 1 %h",
               rec[12].ov, rec[12].ct, aes_encrypt(pt, key));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    offer(rand128(), rand128(), ok);
    repeat (7) tick();
    checks++;
    if (rnd_no !== 4'd7) begin
      errors++;
      $display("[TB] FAIL rst_mid_round: rnd_no=%0d required 7", rnd_no);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, ks_ena, st_load, st_en, mix_en, out_valid, rnd_no, in_ready} !== 11'b00000000001 ||
        {key_q, pt_q} !== 256'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_state: ctl=%b key_q=%h pt_q=%h required 00000000001 0 0",
               {busy, ks_ena, st_load, st_en, mix_en, out_valid, rnd_no, in_ready}, key_q, pt_q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int naccept;
    int nout;
    int last_acc;
    bit held;
    logic [127:0] ek, ep, exp_ct;
    naccept   = 0;
    nout      = 0;
    last_acc  = 0;
    held      = 1'b1;
    ek        = '0;
    ep        = '0;
    exp_ct    = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 60 && nout < 3; i++) begin
      in_pt  = rand128();
      in_key = rand128();
      #1;
      if (naccept > 0 && (key_q !== ek || pt_q !== ep)) held = 1'b0;
      if (out_valid) begin
        nout++;
        checks++;
        if (dp_state !== exp_ct) begin
          errors++;
          $display("[TB] FAIL b2b_ct blk %0d: got %h required %h", nout, dp_state, exp_ct);
        end
      end
      if (in_ready) begin
        if (naccept > 0) begin
          checks++;
          if (cyc - last_acc != 13) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: accepts %0d cycles apart required 13", cyc - last_acc);
          end
        end
        last_acc = cyc;
        ek       = in_key;
        ep       = in_pt;
        exp_ct   = aes_encrypt(ep, ek);
        naccept++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 3 || held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_complete: outputs=%0d capture_held=%b required 3 1", nout, held);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    test_reset();
    test_known_vector();
    test_round_sequence();
    test_backpressure();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 time units, required finished");
    $fatal(1);
  end

endmodule
